// File: rtl/alu_rs_pkg.sv
// Shared widths, opcode encodings and reservation-station sizing for the ALU reservation station.
package alu_rs_pkg;
  localparam int RS_ROB_AW = 4;
  localparam int RS_OPC_W  = 6;
  localparam int RS_XLEN   = 32;
  localparam int RS_DEPTH  = 8;
  localparam int RS_IDX_W  = $clog2(RS_DEPTH);

  typedef enum logic [RS_OPC_W-1:0] {
    OPC_NOP  = 6'd0,
    OPC_ADD  = 6'd1,
    OPC_SUB  = 6'd2,
    OPC_AND  = 6'd3,
    OPC_OR   = 6'd4,
    OPC_XOR  = 6'd5,
    OPC_BEQ  = 6'd16,
    OPC_BNE  = 6'd17,
    OPC_JAL  = 6'd24,
    OPC_JALR = 6'd25
  } opcode_e;
endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-index-first priority encoder: reports whether any request is set and the index of the first one.
module alu_rs_pick #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_found = 1'b1;
        o_idx   = IW'(i);
      end
    end
  end
endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, snoops the CDB for operand tags, issues lowest-index ready entry.
// Defining ALU_RS_LSB_CDB_EN adds a second (load-result) CDB as a wakeup/bypass source.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int DEPTH  = RS_DEPTH,
  parameter int ROB_AW = RS_ROB_AW,
  parameter int OPC_W  = RS_OPC_W,
  parameter int XLEN   = RS_XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr_i,
  input  logic              issEn_i,
  input  logic [OPC_W-1:0]  issOpcode_i,
  input  logic [XLEN-1:0]   issImm_i,
  input  logic [XLEN-1:0]   issPc_i,
  input  logic              issQjV_i,
  input  logic [ROB_AW-1:0] issQj_i,
  input  logic [XLEN-1:0]   issVj_i,
  input  logic              issQkV_i,
  input  logic [ROB_AW-1:0] issQk_i,
  input  logic [XLEN-1:0]   issVk_i,
  input  logic [ROB_AW-1:0] issId_i,
  output logic              rsFull_o,
  input  logic              cdbEn_i,
  input  logic [ROB_AW-1:0] cdbId_i,
  input  logic [XLEN-1:0]   cdbData_i,
`ifdef ALU_RS_LSB_CDB_EN
  input  logic              lsbCdbEn_i,
  input  logic [ROB_AW-1:0] lsbCdbId_i,
  input  logic [XLEN-1:0]   lsbCdbData_i,
`endif
  output logic              aluEn_o,
  output logic [OPC_W-1:0]  aluOpcode_o,
  output logic [XLEN-1:0]   aluImm_o,
  output logic [XLEN-1:0]   aluPc_o,
  output logic [XLEN-1:0]   aluR1Data_o,
  output logic [XLEN-1:0]   aluR2Data_o,
  output logic [ROB_AW-1:0] aluId_o
);
  localparam int IDX_W = (DEPTH == RS_DEPTH) ? RS_IDX_W : $clog2(DEPTH);

  logic [DEPTH-1:0]  r_busy, r_qjv, r_qkv;
  logic [OPC_W-1:0]  r_opc [DEPTH];
  logic [XLEN-1:0]   r_imm [DEPTH];
  logic [XLEN-1:0]   r_pc  [DEPTH];
  logic [ROB_AW-1:0] r_qj  [DEPTH];
  logic [ROB_AW-1:0] r_qk  [DEPTH];
  logic [XLEN-1:0]   r_vj  [DEPTH];
  logic [XLEN-1:0]   r_vk  [DEPTH];
  logic [ROB_AW-1:0] r_id  [DEPTH];

  logic              r_alu_en;
  logic [OPC_W-1:0]  r_alu_opc;
  logic [XLEN-1:0]   r_alu_imm, r_alu_pc, r_alu_r1, r_alu_r2;
  logic [ROB_AW-1:0] r_alu_id;

  logic              w_free_found, w_sel_found, w_alloc;
  logic [IDX_W-1:0]  w_free_idx, w_sel_idx;
  logic [DEPTH-1:0]  w_ready;
  logic              w_lsb_en;
  logic [ROB_AW-1:0] w_lsb_id;
  logic [XLEN-1:0]   w_lsb_dat;
  logic              w_iss_qjv, w_iss_qkv;
  logic [XLEN-1:0]   w_iss_vj, w_iss_vk;

`ifdef ALU_RS_LSB_CDB_EN
  assign w_lsb_en  = lsbCdbEn_i;
  assign w_lsb_id  = lsbCdbId_i;
  assign w_lsb_dat = lsbCdbData_i;
`else
  assign w_lsb_en  = 1'b0;
  assign w_lsb_id  = '0;
  assign w_lsb_dat = '0;
`endif

  assign w_ready  = r_busy & ~r_qjv & ~r_qkv;
  assign rsFull_o = &r_busy;
  assign w_alloc  = issEn_i & w_free_found;

  alu_rs_pick #(.N(DEPTH), .IW(IDX_W)) u_free_pick (
    .i_req  (~r_busy),
    .o_found(w_free_found),
    .o_idx  (w_free_idx)
  );

  alu_rs_pick #(.N(DEPTH), .IW(IDX_W)) u_sel_pick (
    .i_req  (w_ready),
    .o_found(w_sel_found),
    .o_idx  (w_sel_idx)
  );

  // Same-cycle bypass on the incoming op; the ALU bus is evaluated last so it wins a double match.
  always_comb begin
    w_iss_qjv = issQjV_i;
    w_iss_vj  = issVj_i;
    w_iss_qkv = issQkV_i;
    w_iss_vk  = issVk_i;
    if (issQjV_i && w_lsb_en && (w_lsb_id == issQj_i)) begin
      w_iss_qjv = 1'b0;
      w_iss_vj  = w_lsb_dat;
    end
    if (issQjV_i && cdbEn_i && (cdbId_i == issQj_i)) begin
      w_iss_qjv = 1'b0;
      w_iss_vj  = cdbData_i;
    end
    if (issQkV_i && w_lsb_en && (w_lsb_id == issQk_i)) begin
      w_iss_qkv = 1'b0;
      w_iss_vk  = w_lsb_dat;
    end
    if (issQkV_i && cdbEn_i && (cdbId_i == issQk_i)) begin
      w_iss_qkv = 1'b0;
      w_iss_vk  = cdbData_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy    <= '0;
      r_qjv     <= '0;
      r_qkv     <= '0;
      r_alu_en  <= 1'b0;
      r_alu_opc <= '0;
      r_alu_imm <= '0;
      r_alu_pc  <= '0;
      r_alu_r1  <= '0;
      r_alu_r2  <= '0;
      r_alu_id  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_opc[i] <= '0;
        r_imm[i] <= '0;
        r_pc[i]  <= '0;
        r_qj[i]  <= '0;
        r_qk[i]  <= '0;
        r_vj[i]  <= '0;
        r_vk[i]  <= '0;
        r_id[i]  <= '0;
      end
    end else if (rdy) begin
      if (clr_i) begin
        r_busy   <= '0;
        r_alu_en <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_busy[i] && r_qjv[i] && w_lsb_en && (r_qj[i] == w_lsb_id)) begin
            r_qjv[i] <= 1'b0;
            r_vj[i]  <= w_lsb_dat;
          end
          if (r_busy[i] && r_qjv[i] && cdbEn_i && (r_qj[i] == cdbId_i)) begin
            r_qjv[i] <= 1'b0;
            r_vj[i]  <= cdbData_i;
          end
          if (r_busy[i] && r_qkv[i] && w_lsb_en && (r_qk[i] == w_lsb_id)) begin
            r_qkv[i] <= 1'b0;
            r_vk[i]  <= w_lsb_dat;
          end
          if (r_busy[i] && r_qkv[i] && cdbEn_i && (r_qk[i] == cdbId_i)) begin
            r_qkv[i] <= 1'b0;
            r_vk[i]  <= cdbData_i;
          end
        end
        if (w_sel_found) begin
          r_alu_en          <= 1'b1;
          r_alu_opc         <= r_opc[w_sel_idx];
          r_alu_imm         <= r_imm[w_sel_idx];
          r_alu_pc          <= r_pc[w_sel_idx];
          r_alu_r1          <= r_vj[w_sel_idx];
          r_alu_r2          <= r_vk[w_sel_idx];
          r_alu_id          <= r_id[w_sel_idx];
          r_busy[w_sel_idx] <= 1'b0;
        end else begin
          r_alu_en <= 1'b0;
        end
        // Free slot is never the selected slot, so these writes never collide with the select.
        if (w_alloc) begin
          r_busy[w_free_idx] <= 1'b1;
          r_opc[w_free_idx]  <= issOpcode_i;
          r_imm[w_free_idx]  <= issImm_i;
          r_pc[w_free_idx]   <= issPc_i;
          r_qjv[w_free_idx]  <= w_iss_qjv;
          r_qj[w_free_idx]   <= issQj_i;
          r_vj[w_free_idx]   <= w_iss_vj;
          r_qkv[w_free_idx]  <= w_iss_qkv;
          r_qk[w_free_idx]   <= issQk_i;
          r_vk[w_free_idx]   <= w_iss_vk;
          r_id[w_free_idx]   <= issId_i;
        end
      end
    end
  end

`ifdef ALU_RS_LSB_CDB_EN
  always_ff @(posedge clk) begin
    if (rst && rdy && cdbEn_i && lsbCdbEn_i) begin
      assert (cdbId_i != lsbCdbId_i);
    end
  end
`endif

  assign aluEn_o     = r_alu_en;
  assign aluOpcode_o = r_alu_opc;
  assign aluImm_o    = r_alu_imm;
  assign aluPc_o     = r_alu_pc;
  assign aluR1Data_o = r_alu_r1;
  assign aluR2Data_o = r_alu_r2;
  assign aluId_o     = r_alu_id;
endmodule
